// File: rtl/console_writer.sv
`default_nettype none
// ============================================================================
//  Module      : console_writer
//  Description : Text console cursor engine. Accepts a character stream,
//                writes printable codes into a character array at the cursor
//                and handles BS / LF / CR cursor control with wrap-around.
//                Optional feature macro CONSOLE_CLEAR_EN: FF (0x0C) starts a
//                full-screen blank sweep in raster order.
//  Revision    : 1.0 - initial release
// ============================================================================
module console_writer #(
    parameter int         WIDTH      = 80,
    parameter int         HEIGHT     = 45,
    parameter logic [7:0] BLANK_CHAR = 8'h20
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        in_valid,
    output logic        in_ready,
    input  logic [7:0]  in_char,
    input  logic [11:0] in_color,
    output logic        w_en,
    output logic [7:0]  w_pos_x,
    output logic [7:0]  w_pos_y,
    output logic [7:0]  w_char,
    output logic [11:0] w_color,
    output logic [7:0]  cursor_x,
    output logic [7:0]  cursor_y,
    output logic        busy
);

    localparam logic [7:0] c_last_x = 8'(WIDTH - 1);
    localparam logic [7:0] c_last_y = 8'(HEIGHT - 1);
    localparam logic [7:0] c_bs     = 8'h08;
    localparam logic [7:0] c_lf     = 8'h0A;
    localparam logic [7:0] c_ff     = 8'h0C;
    localparam logic [7:0] c_cr     = 8'h0D;

`ifdef CONSOLE_CLEAR_EN
    typedef enum logic [0:0] {
        S_IDLE  = 1'b0,
        S_CLEAR = 1'b1
    } state_t;
`else
    typedef enum logic [0:0] {
        S_IDLE  = 1'b0
    } state_t;
`endif

    state_t      r_state, w_nxt_state;
    logic        r_ready, w_nxt_ready;
    logic [7:0]  r_cur_x, w_nxt_cur_x;
    logic [7:0]  r_cur_y, w_nxt_cur_y;
    logic        r_wen,   w_nxt_wen;
    logic [7:0]  r_wx,    w_nxt_wx;
    logic [7:0]  r_wy,    w_nxt_wy;
    logic [7:0]  r_wch,   w_nxt_wch;
    logic [11:0] r_wcol,  w_nxt_wcol;
    logic        w_accept;
    logic [7:0]  w_row_inc;

`ifdef CONSOLE_CLEAR_EN
    // Set once the final cell of the sweep has been issued; the following
    // cycle hands control back to IDLE.
    logic        r_clr_last, w_nxt_clr_last;
    logic [7:0]  w_sweep_x, w_sweep_y;
`endif

    assign w_accept  = in_valid && r_ready;
    assign w_row_inc = (r_cur_y == c_last_y) ? 8'd0 : r_cur_y + 8'd1;

`ifdef CONSOLE_CLEAR_EN
    // Next raster cell after the one last written (the w_pos registers
    // double as the sweep counter).
    assign w_sweep_x = (r_wx == c_last_x) ? 8'd0 : r_wx + 8'd1;
    assign w_sweep_y = (r_wx == c_last_x) ? r_wy + 8'd1 : r_wy;
`endif

    // Next-state, cursor and write-port decode
    always_comb begin
        w_nxt_state = r_state;
        w_nxt_ready = r_ready;
        w_nxt_cur_x = r_cur_x;
        w_nxt_cur_y = r_cur_y;
        w_nxt_wen   = 1'b0;
        w_nxt_wx    = r_wx;
        w_nxt_wy    = r_wy;
        w_nxt_wch   = r_wch;
        w_nxt_wcol  = r_wcol;
`ifdef CONSOLE_CLEAR_EN
        w_nxt_clr_last = r_clr_last;
`endif
        case (r_state)
            S_IDLE: begin
                w_nxt_ready = 1'b1;
                if (w_accept) begin
                    case (in_char)
                        c_lf: begin
                            w_nxt_cur_x = 8'd0;
                            w_nxt_cur_y = w_row_inc;
                        end
                        c_cr: begin
                            w_nxt_cur_x = 8'd0;
                        end
                        c_bs: begin
                            if (r_cur_x != 8'd0) begin
                                w_nxt_cur_x = r_cur_x - 8'd1;
                                w_nxt_wen   = 1'b1;
                                w_nxt_wx    = r_cur_x - 8'd1;
                                w_nxt_wy    = r_cur_y;
                                w_nxt_wch   = BLANK_CHAR;
                                w_nxt_wcol  = in_color;
                            end else if (r_cur_y != 8'd0) begin
                                w_nxt_cur_x = c_last_x;
                                w_nxt_cur_y = r_cur_y - 8'd1;
                                w_nxt_wen   = 1'b1;
                                w_nxt_wx    = c_last_x;
                                w_nxt_wy    = r_cur_y - 8'd1;
                                w_nxt_wch   = BLANK_CHAR;
                                w_nxt_wcol  = in_color;
                            end
                        end
                        c_ff: begin
`ifdef CONSOLE_CLEAR_EN
                            // First sweep write goes out with the acceptance
                            // edge; the colour is held in w_color for the rest.
                            w_nxt_state    = S_CLEAR;
                            w_nxt_ready    = 1'b0;
                            w_nxt_cur_x    = 8'd0;
                            w_nxt_cur_y    = 8'd0;
                            w_nxt_wen      = 1'b1;
                            w_nxt_wx       = 8'd0;
                            w_nxt_wy       = 8'd0;
                            w_nxt_wch      = BLANK_CHAR;
                            w_nxt_wcol     = in_color;
                            w_nxt_clr_last = (WIDTH * HEIGHT == 1);
`endif
                        end
                        default: begin
                            w_nxt_wen  = 1'b1;
                            w_nxt_wx   = r_cur_x;
                            w_nxt_wy   = r_cur_y;
                            w_nxt_wch  = in_char;
                            w_nxt_wcol = in_color;
                            if (r_cur_x == c_last_x) begin
                                w_nxt_cur_x = 8'd0;
                                w_nxt_cur_y = w_row_inc;
                            end else begin
                                w_nxt_cur_x = r_cur_x + 8'd1;
                            end
                        end
                    endcase
                end
            end
`ifdef CONSOLE_CLEAR_EN
            S_CLEAR: begin
                w_nxt_ready = 1'b0;
                if (r_clr_last) begin
                    w_nxt_state    = S_IDLE;
                    w_nxt_ready    = 1'b1;
                    w_nxt_clr_last = 1'b0;
                end else begin
                    w_nxt_wen      = 1'b1;
                    w_nxt_wx       = w_sweep_x;
                    w_nxt_wy       = w_sweep_y;
                    w_nxt_wch      = BLANK_CHAR;
                    w_nxt_clr_last = (w_sweep_x == c_last_x) && (w_sweep_y == c_last_y);
                end
            end
`endif
            default: begin
                w_nxt_state = S_IDLE;
            end
        endcase
    end

    // State, cursor and registered write-port outputs
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= S_IDLE;
            r_ready <= 1'b0;
            r_cur_x <= 8'd0;
            r_cur_y <= 8'd0;
            r_wen   <= 1'b0;
            r_wx    <= 8'd0;
            r_wy    <= 8'd0;
            r_wch   <= 8'd0;
            r_wcol  <= 12'd0;
`ifdef CONSOLE_CLEAR_EN
            r_clr_last <= 1'b0;
`endif
        end else begin
            r_state <= w_nxt_state;
            r_ready <= w_nxt_ready;
            r_cur_x <= w_nxt_cur_x;
            r_cur_y <= w_nxt_cur_y;
            r_wen   <= w_nxt_wen;
            r_wx    <= w_nxt_wx;
            r_wy    <= w_nxt_wy;
            r_wch   <= w_nxt_wch;
            r_wcol  <= w_nxt_wcol;
`ifdef CONSOLE_CLEAR_EN
            r_clr_last <= w_nxt_clr_last;
`endif
        end
    end

    assign in_ready = r_ready;
    assign w_en     = r_wen;
    assign w_pos_x  = r_wx;
    assign w_pos_y  = r_wy;
    assign w_char   = r_wch;
    assign w_color  = r_wcol;
    assign cursor_x = r_cur_x;
    assign cursor_y = r_cur_y;
`ifdef CONSOLE_CLEAR_EN
    assign busy     = (r_state == S_CLEAR);
`else
    assign busy     = 1'b0;
`endif

endmodule
`default_nettype wire

// File: tb/tb_console_writer.sv
`default_nettype none
// ============================================================================
//  Module      : tb_console_writer
//  Description : Directed self-checking bench for console_writer (80x45,
//                blank 0x20). Covers CONSOLE_CLEAR_EN in either build.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_console_writer;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        in_valid = 1'b0;
    logic        in_ready;
    logic [7:0]  in_char = 8'd0;
    logic [11:0] in_color = 12'd0;
    logic        w_en;
    logic [7:0]  w_pos_x, w_pos_y, w_char, cursor_x, cursor_y;
    logic [11:0] w_color;
    logic        busy;

    int n_checks = 0;
    int n_fail   = 0;

    console_writer #(.WIDTH(80), .HEIGHT(45), .BLANK_CHAR(8'h20)) dut (
        .clk      (clk),
        .rst      (rst),
        .in_valid (in_valid),
        .in_ready (in_ready),
        .in_char  (in_char),
        .in_color (in_color),
        .w_en     (w_en),
        .w_pos_x  (w_pos_x),
        .w_pos_y  (w_pos_y),
        .w_char   (w_char),
        .w_color  (w_color),
        .cursor_x (cursor_x),
        .cursor_y (cursor_y),
        .busy     (busy)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    // Called at a negedge; offers one character, returns at the negedge
    // following its acceptance edge.
    task automatic put(input logic [7:0] ch, input logic [11:0] col);
        check("ready_before_put", 32'(in_ready), 32'd1);
        in_valid = 1'b1;
        in_char  = ch;
        in_color = col;
        @(posedge clk);
        @(negedge clk);
        in_valid = 1'b0;
    endtask

    task automatic expect_out(input string tag, input int wen, input int wx, input int wy,
                              input int wch, input int wcol, input int cx, input int cy);
        check({tag, "_wen"}, 32'(w_en), 32'(wen));
        if (wen != 0) begin
            check({tag, "_wx"},   32'(w_pos_x), 32'(wx));
            check({tag, "_wy"},   32'(w_pos_y), 32'(wy));
            check({tag, "_wch"},  32'(w_char),  32'(wch));
            check({tag, "_wcol"}, 32'(w_color), 32'(wcol));
        end
        check({tag, "_cx"}, 32'(cursor_x), 32'(cx));
        check({tag, "_cy"}, 32'(cursor_y), 32'(cy));
    endtask

    task automatic check_reset_state(input string tag);
        check({tag, "_wen"},   32'(w_en),     32'd0);
        check({tag, "_wx"},    32'(w_pos_x),  32'd0);
        check({tag, "_wy"},    32'(w_pos_y),  32'd0);
        check({tag, "_wch"},   32'(w_char),   32'd0);
        check({tag, "_wcol"},  32'(w_color),  32'd0);
        check({tag, "_cx"},    32'(cursor_x), 32'd0);
        check({tag, "_cy"},    32'(cursor_y), 32'd0);
        check({tag, "_busy"},  32'(busy),     32'd0);
        check({tag, "_ready"}, 32'(in_ready), 32'd0);
    endtask

    initial begin
        int errs;
        int stray;

        // Reset values
        @(negedge clk);
        @(negedge clk);
        check_reset_state("reset");
        rst = 1'b0;
        check("ready_before_edge", 32'(in_ready), 32'd0);
        @(negedge clk);
        check("ready_after_release", 32'(in_ready), 32'd1);

        // Single printable write, one-cycle strobe
        put(8'h41, 12'hF00);
        expect_out("char_A", 1, 0, 0, 8'h41, 12'hF00, 1, 0);
        @(negedge clk);
        expect_out("strobe_drop", 0, 0, 0, 0, 0, 1, 0);

        // CR back to column 0, "AB" back-to-back, CR, LF
        put(8'h0D, 12'h000);
        expect_out("cr1", 0, 0, 0, 0, 0, 0, 0);
        put(8'h41, 12'h111);
        expect_out("ab_A", 1, 0, 0, 8'h41, 12'h111, 1, 0);
        put(8'h42, 12'h222);
        expect_out("ab_B", 1, 1, 0, 8'h42, 12'h222, 2, 0);
        put(8'h0D, 12'h000);
        expect_out("ab_cr", 0, 0, 0, 0, 0, 0, 0);
        put(8'h0A, 12'h000);
        expect_out("ab_lf", 0, 0, 0, 0, 0, 0, 1);

        // Backspace across a row boundary, then a plain backspace
        put(8'h0A, 12'h000);
        put(8'h0A, 12'h000);
        expect_out("to_0_3", 0, 0, 0, 0, 0, 0, 3);
        put(8'h08, 12'h000);
        expect_out("bs_wrap", 1, 79, 2, 8'h20, 12'h000, 79, 2);
        put(8'h08, 12'h123);
        expect_out("bs_plain", 1, 78, 2, 8'h20, 12'h123, 78, 2);

        // LF wraps from the last row back to row 0; BS at origin is a no-op
        put(8'h0D, 12'h000);
        for (int i = 0; i < 43; i++) put(8'h0A, 12'h000);
        expect_out("lf_wrap", 0, 0, 0, 0, 0, 0, 0);
        put(8'h08, 12'h555);
        expect_out("bs_origin", 0, 0, 0, 0, 0, 0, 0);

        // Printable at the bottom-right cell wraps to the origin
        for (int i = 0; i < 44; i++) put(8'h0A, 12'h000);
        for (int i = 0; i < 79; i++) put(8'h78, 12'h000);
        expect_out("at_79_44", 1, 78, 44, 8'h78, 12'h000, 79, 44);
        put(8'h5A, 12'hABC);
        expect_out("z_wrap", 1, 79, 44, 8'h5A, 12'hABC, 0, 0);

        put(8'h51, 12'h00F);
        expect_out("char_Q", 1, 0, 0, 8'h51, 12'h00F, 1, 0);

`ifdef CONSOLE_CLEAR_EN
        // Full-screen clear sweep
        put(8'h0C, 12'h0F0);
        errs = 0;
        for (int i = 0; i < 3600; i++) begin
            if (w_en !== 1'b1 || 32'(w_pos_x) !== 32'(i % 80) || 32'(w_pos_y) !== 32'(i / 80) ||
                w_char !== 8'h20 || w_color !== 12'h0F0 || in_ready !== 1'b0 || busy !== 1'b1)
                errs++;
            if (i < 3599) @(negedge clk);
        end
        check("clear_sweep_errs", 32'(errs), 32'd0);
        @(negedge clk);
        check("clear_done_wen",   32'(w_en),     32'd0);
        check("clear_done_ready", 32'(in_ready), 32'd1);
        check("clear_done_busy",  32'(busy),     32'd0);
        check("clear_done_cx",    32'(cursor_x), 32'd0);
        check("clear_done_cy",    32'(cursor_y), 32'd0);

        // Reset during a sweep at the 1000th write
        put(8'h41, 12'h000);
        put(8'h0C, 12'h0F0);
        for (int i = 0; i < 999; i++) @(negedge clk);
        expect_out("clr_w1000", 1, 39, 12, 8'h20, 12'h0F0, 0, 0);
        check("clr_w1000_busy", 32'(busy), 32'd1);
`else
        // FF is swallowed without effect
        put(8'h0C, 12'h0F0);
        expect_out("ff_ignored", 0, 0, 0, 0, 0, 1, 0);
        check("ff_busy", 32'(busy), 32'd0);
        @(negedge clk);
        check("ff_ready", 32'(in_ready), 32'd1);

        // Reset in the middle of a write strobe
        put(8'h43, 12'h321);
        expect_out("pre_rst", 1, 1, 0, 8'h43, 12'h321, 2, 0);
`endif
        #1 rst = 1'b1;
        #1 check_reset_state("async_rst");
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        check("ready_after_rst", 32'(in_ready), 32'd1);
        stray = 0;
        for (int i = 0; i < 20; i++) begin
            if (w_en !== 1'b0 || busy !== 1'b0) stray++;
            @(negedge clk);
        end
        check("no_writes_after_rst", 32'(stray), 32'd0);
        put(8'h41, 12'h0AA);
        expect_out("post_rst_A", 1, 0, 0, 8'h41, 12'h0AA, 1, 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
